// File: rtl/matrix_vector_mac.sv
// Sequential 2D point transform: rows 0 and 1 of a 3x3 homogeneous matrix times (x, y, 1),
// evaluated with a single multiplier and accumulator, one column per cycle.
module matrix_vector_mac #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [1:0]                     transform_type,
   input  logic signed [DATA_WIDTH-1:0]   x_in,
   input  logic signed [DATA_WIDTH-1:0]   y_in,
   input  logic signed [DATA_WIDTH-1:0]   param1,
   input  logic signed [DATA_WIDTH-1:0]   param2,
   output logic signed [2*DATA_WIDTH-1:0] matrix_result,
   output logic                           matrix_valid,
   output logic                           busy,
   output logic                           done
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int AW = PW + 2;

   localparam logic [1:0] TypeRotate    = 2'b00;
   localparam logic [1:0] TypeScale     = 2'b01;
   localparam logic [1:0] TypeTranslate = 2'b10;

   localparam logic signed [DATA_WIDTH-1:0] CosPos = DATA_WIDTH'(91);
   localparam logic signed [DATA_WIDTH-1:0] CosNeg = DATA_WIDTH'(-91);
   localparam logic signed [DATA_WIDTH-1:0] One    = DATA_WIDTH'(1);
   localparam logic signed [DATA_WIDTH-1:0] Zero   = '0;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StMacRow0,
      StEmitX,
      StMacRow1,
      StEmitY
   } state_t;

   state_t                        state_q;
   logic [1:0]                    type_q;
   logic signed [DATA_WIDTH-1:0]  x_q, y_q, p1_q, p2_q;
   logic [1:0]                    col_q;
   logic signed [AW-1:0]          acc_q;

   logic                          row1;
   logic signed [DATA_WIDTH-1:0]  coef;
   logic signed [DATA_WIDTH-1:0]  vec;
   logic signed [PW-1:0]          product;
   logic signed [AW-1:0]          acc_next;
   logic signed [AW-1:0]          row_result;

   // Coefficient M[row][col] for the current column, and the matching vector element.
   always_comb begin
      row1 = (state_q == StMacRow1);
      coef = Zero;
      unique case (type_q)
         TypeRotate: begin
            if (col_q == 2'd0)      coef = CosPos;
            else if (col_q == 2'd1) coef = row1 ? CosPos : CosNeg;
         end
         TypeScale: begin
            if (col_q == 2'd0)      coef = row1 ? Zero : p1_q;
            else if (col_q == 2'd1) coef = row1 ? p2_q : Zero;
         end
         TypeTranslate: begin
            if (col_q == 2'd0)      coef = row1 ? Zero : One;
            else if (col_q == 2'd1) coef = row1 ? One : Zero;
            else                    coef = row1 ? p2_q : p1_q;
         end
         default: begin
            if (col_q == 2'd0)      coef = row1 ? Zero : One;
            else if (col_q == 2'd1) coef = row1 ? One : Zero;
         end
      endcase

      unique case (col_q)
         2'd0:    vec = x_q;
         2'd1:    vec = y_q;
         default: vec = One;
      endcase

      product  = {{DATA_WIDTH{coef[DATA_WIDTH-1]}}, coef}
               * {{DATA_WIDTH{vec[DATA_WIDTH-1]}}, vec};
      acc_next = acc_q + {{2{product[PW-1]}}, product};
      // Rotation coefficients are cos45 scaled by 128; arithmetic shift floors.
      row_result = (type_q == TypeRotate) ? (acc_q >>> 7) : acc_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         type_q        <= '0;
         x_q           <= '0;
         y_q           <= '0;
         p1_q          <= '0;
         p2_q          <= '0;
         col_q         <= '0;
         acc_q         <= '0;
         matrix_result <= '0;
         matrix_valid  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         matrix_valid <= 1'b0;
         done         <= 1'b0;
         unique case (state_q)
            StIdle: begin
               busy <= start;
               if (start) begin
                  type_q  <= transform_type;
                  x_q     <= x_in;
                  y_q     <= y_in;
                  p1_q    <= param1;
                  p2_q    <= param2;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               acc_q   <= '0;
               col_q   <= '0;
               state_q <= StMacRow0;
            end
            StMacRow0, StMacRow1: begin
               acc_q <= acc_next;
               col_q <= col_q + 2'd1;
               if (col_q == 2'd2) begin
                  state_q <= (state_q == StMacRow0) ? StEmitX : StEmitY;
               end
            end
            StEmitX: begin
               matrix_result <= row_result[PW-1:0];
               matrix_valid  <= 1'b1;
               acc_q         <= '0;
               col_q         <= '0;
               state_q       <= StMacRow1;
            end
            StEmitY: begin
               matrix_result <= row_result[PW-1:0];
               matrix_valid  <= 1'b1;
               done          <= 1'b1;
               state_q       <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/matrix_vector_mac.md
MATRIX_VECTOR_MAC -- requirements
Module: matrix_vector_mac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the signed width of coordinate and parameter inputs.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to compute one transformed point.
REQ-005 SHALL have port transform_type, input, 2, selecting 00=rotate 45 deg, 01=scale, 10=translate, 11=identity.
REQ-006 SHALL have ports x_in and y_in, input, DATA_WIDTH each, the signed point coordinates.
REQ-007 SHALL have ports param1 and param2, input, DATA_WIDTH each, signed: scale_x/scale_y or tx/ty; ignored for rotate and identity.
REQ-008 SHALL have port matrix_result, output, 2*DATA_WIDTH, the signed transformed coordinate (x' first, then y').
REQ-009 SHALL have port matrix_valid, output, 1, a one-cycle strobe qualifying matrix_result.
REQ-010 SHALL have port busy, output, 1, high from start acceptance until the cycle after y' is emitted.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse coincident with the y' strobe.

Function
REQ-012 SHALL compute [x' y']^T = rows 0 and 1 of a 3x3 matrix M times the homogeneous vector (x, y, 1), using one multiplier and one accumulator sequentially.
REQ-013 SHALL build M by type as follows: rotate [91 -91 0; 91 91 0]; scale [p1 0 0; 0 p2 0]; translate [1 0 p1; 0 1 p2]; identity [1 0 0; 0 1 0].
REQ-014 SHALL use a signed accumulator of 2*DATA_WIDTH+2 bits, with each product formed as a full signed 2*DATA_WIDTH product.
REQ-015 SHALL, for rotate, make the row result the accumulator arithmetically shifted right 7 (floor); for other types, make it the accumulator unshifted.
REQ-016 SHALL drive matrix_result as the low 2*DATA_WIDTH bits of the row result; no overflow is possible for these coefficient sets.
REQ-017 SHALL implement FSM states IDLE, SETUP, MAC_ROW0, EMIT_X, MAC_ROW1, EMIT_Y.
REQ-018 SHALL, in IDLE with start=1, latch x_in, y_in, param1, param2 and transform_type on that edge, set busy=1, and go to SETUP.
REQ-019 SHALL, in SETUP, clear the accumulator, clear the column counter, and go to MAC_ROW0.
REQ-020 SHALL, in MAC_ROW0 and MAC_ROW1, accumulate one column per cycle, k = 0, 1, 2, leaving after k=2 for EMIT_X or EMIT_Y respectively.
REQ-021 SHALL, in EMIT_X, register x' and pulse matrix_valid, clear the accumulator and column counter, and go to MAC_ROW1.
REQ-022 SHALL, in EMIT_Y, register y', pulse matrix_valid and done, and go to IDLE; busy drops on the next edge.
REQ-023 SHALL meet this latency, counting rising edges after the edge that samples start: x' strobe visible after edge 5, y' strobe after edge 9; the next start is accepted at edge 10 at the earliest.
REQ-024 SHALL ignore start whenever state is not IDLE; input changes after latch do not affect the result in progress.
REQ-025 SHALL separate the two matrix_valid strobes by exactly 3 low cycles; matrix_valid is never high two cycles in a row.
REQ-026 SHALL hold matrix_result at the last emitted value between strobes.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-operation, immediately force state=IDLE, accumulator=0, matrix_result=0, matrix_valid=0, done=0, busy=0.
REQ-028 SHALL produce no strobe from an aborted operation after rst_n releases; the first start after release is handled normally.

Verification
REQ-029 SHALL verify scale: type=01, x=3, y=-4, p1=2, p2=5 -> result 0x0006 strobed after edge 5, 0xFFEC strobed after edge 9 with done=1.
REQ-030 SHALL verify translate: type=10, x=5, y=10, p1=5, p2=10 -> 0x000A then 0x0014; identity (type=11, x=-7, y=9) -> 0xFFF9 then 0x0009.
REQ-031 SHALL verify rotate: x=100, y=0 -> 71 then 71; x=-100, y=0 -> -72 (0xFFB8) then -72, proving floor shift.
REQ-032 SHALL verify start held high for 20 cycles -> exactly two complete operations (starts accepted at edges 0 and 10), with 4 strobes total and no overlap.
REQ-033 SHALL verify reset mid-operation: rst_n low during MAC_ROW1 -> all outputs 0 immediately, no strobe after release, and a following scale op is correct.
REQ-034 SHALL verify input change after start: x_in altered at edge 2 -> result reflects the latched x only.
